// File: rtl/mig_mem_responder.sv
// Behavioural memory responder for an MIG-style user port: single shared address
// channel for read and write bursts, byte-strobed writes, fixed read latency.
module mig_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    arvalid,
    input  logic                    awvalid,
    input  logic [7:0]              arwlen,
    output logic                    arready,
    output logic                    awready,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    wready,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    data_valid,
    output logic                    rw_last,
    output logic                    proto_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_HI     = DEPTH_LOG2 + OFF_BITS;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 2);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP} state_t;

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   beat_idx;
    logic [DEPTH_LOG2-1:0]   start_idx;
    logic [7:0]              burst_len;
    logic [7:0]              beat_cnt;
    logic [7:0]              wait_cnt;
    logic                    last_beat;
    logic                    wr_fire;
    logic                    unused_addr_bits;

    assign start_idx        = addr[IDX_HI-1:OFF_BITS];
    assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:IDX_HI], addr[OFF_BITS-1:0]};
    assign last_beat        = (beat_cnt == burst_len);
    assign wr_fire          = (state == WR_DATA) && wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reads win a simultaneous request, so awready is masked while arvalid is up.
    always_comb begin
        next_state = state;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
                if (arvalid) begin
                    next_state = (RD_LAT > 1) ? RD_WAIT : RD_BURST;
                end else if (awvalid) begin
                    next_state = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = RD_BURST;
                end
            end
            RD_BURST: begin
                if (last_beat) begin
                    next_state = IDLE;
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid && last_beat) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx   <= '0;
            burst_len  <= '0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            data_valid <= 1'b0;
            rw_last    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            rw_last    <= 1'b0;
            case (state)
                IDLE: begin
                    if (arvalid || awvalid) begin
                        beat_idx  <= start_idx;
                        burst_len <= arwlen;
                        beat_cnt  <= '0;
                        wait_cnt  <= '0;
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                RD_BURST: begin
                    data_valid <= 1'b1;
                    rw_last    <= last_beat;
                    beat_idx   <= beat_idx + 1'b1;
                    beat_cnt   <= beat_cnt + 8'd1;
                end
                WR_DATA: begin
                    if (wvalid) begin
                        beat_idx <= beat_idx + 1'b1;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (wlast != last_beat) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and read data carry no reset so memory contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[beat_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        data <= mem[beat_idx];
    end

endmodule

// File: tb/tb_mig_mem_responder.sv
// Directed bench for mig_mem_responder: writes, latency-checked reads, strobe wrap,
// read/write arbitration, wlast protocol error and mid-burst reset.
module tb_mig_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         arvalid, awvalid;
    logic [7:0]   arwlen;
    logic         arready, awready;
    logic         wvalid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wready, bvalid, bready;
    logic [511:0] data;
    logic         data_valid, rw_last, proto_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [511:0] pat_a5, pat_11, pat_22, pat_33, pat_44, pat_77;
    logic [511:0] exp_255, exp_0;

    always #5 clk = ~clk;

    mig_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .arvalid    (arvalid),
        .awvalid    (awvalid),
        .arwlen     (arwlen),
        .arready    (arready),
        .awready    (awready),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wready     (wready),
        .bvalid     (bvalid),
        .bready     (bready),
        .data       (data),
        .data_valid (data_valid),
        .rw_last    (rw_last),
        .proto_err  (proto_err)
    );

    task automatic check_output(input string tag, input logic [511:0] observed,
                                input logic [511:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_addr(input logic [31:0] a, input logic [7:0] len);
        addr    = a;
        arwlen  = len;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
    endtask

    task automatic read_addr(input logic [31:0] a, input logic [7:0] len);
        addr    = a;
        arwlen  = len;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
    endtask

    task automatic write_beat(input logic [511:0] d, input logic [63:0] s, input logic l);
        wdata  = d;
        wstrb  = s;
        wlast  = l;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic write_resp();
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    initial begin
        pat_a5  = {64{8'hA5}};
        pat_11  = {64{8'h11}};
        pat_22  = {64{8'h22}};
        pat_33  = {64{8'h33}};
        pat_44  = {64{8'h44}};
        pat_77  = {64{8'h77}};
        exp_255 = {{63{8'hC3}}, 8'h5A};
        exp_0   = {{63{8'h3C}}, 8'h96};

        rst = 1'b1; addr = '0; arvalid = 0; awvalid = 0; arwlen = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
        step(); step();
        check_output("rst_data_valid", data_valid, 1'b0);
        check_output("rst_bvalid", bvalid, 1'b0);
        check_output("rst_wready", wready, 1'b0);
        check_output("rst_proto_err", proto_err, 1'b0);
        rst = 1'b0;
        step();
        check_output("post_rst_arready", arready, 1'b1);
        check_output("post_rst_awready", awready, 1'b1);

        // Single-beat write with held response.
        write_addr(32'h40, 8'd0);
        check_output("w1_wready", wready, 1'b1);
        check_output("w1_awready_busy", awready, 1'b0);
        write_beat(pat_a5, '1, 1'b1);
        check_output("w1_wready_done", wready, 1'b0);
        check_output("w1_bvalid", bvalid, 1'b1);
        step();
        check_output("w1_bvalid_held", bvalid, 1'b1);
        write_resp();
        check_output("w1_bvalid_clear", bvalid, 1'b0);
        check_output("w1_proto_err", proto_err, 1'b0);

        // Four-beat write to beats 1..4, then read back with latency check.
        write_addr(32'h40, 8'd3);
        write_beat(pat_11, '1, 1'b0);
        write_beat(pat_22, '1, 1'b0);
        write_beat(pat_33, '1, 1'b0);
        write_beat(pat_44, '1, 1'b1);
        check_output("w4_bvalid", bvalid, 1'b1);
        write_resp();
        read_addr(32'h40, 8'd3);
        check_output("r4_lat0_dv", data_valid, 1'b0);
        step();
        check_output("r4_lat1_dv", data_valid, 1'b0);
        step();
        check_output("r4_b0_dv", data_valid, 1'b1);
        check_output("r4_b0_data", data, pat_11);
        check_output("r4_b0_last", rw_last, 1'b0);
        step();
        check_output("r4_b1_data", data, pat_22);
        check_output("r4_b1_last", rw_last, 1'b0);
        step();
        check_output("r4_b2_data", data, pat_33);
        check_output("r4_b2_last", rw_last, 1'b0);
        step();
        check_output("r4_b3_dv", data_valid, 1'b1);
        check_output("r4_b3_data", data, pat_44);
        check_output("r4_b3_last", rw_last, 1'b1);
        step();
        check_output("r4_end_dv", data_valid, 1'b0);
        check_output("r4_end_arready", arready, 1'b1);

        // Strobed write wrapping from beat 255 to beat 0.
        write_addr(32'h3FC0, 8'd1);
        write_beat({64{8'hC3}}, '1, 1'b0);
        write_beat({64{8'h3C}}, '1, 1'b1);
        write_resp();
        write_addr(32'h1000_3FC0, 8'd1);
        write_beat({64{8'h5A}}, 64'h1, 1'b0);
        write_beat({64{8'h96}}, 64'h1, 1'b1);
        write_resp();
        read_addr(32'h3FC5, 8'd1);
        step(); step();
        check_output("wrap_b255_data", data, exp_255);
        step();
        check_output("wrap_b0_data", data, exp_0);
        check_output("wrap_b0_last", rw_last, 1'b1);
        step();

        // Simultaneous read and write: read wins, write waits for rw_last.
        addr = 32'h40; arwlen = 8'd0; arvalid = 1'b1; awvalid = 1'b1;
        #1;
        check_output("arb_arready", arready, 1'b1);
        check_output("arb_awready", awready, 1'b0);
        step();
        arvalid = 1'b0; addr = 32'h80;
        check_output("arb_wait_awready", awready, 1'b0);
        step();
        check_output("arb_burst_awready", awready, 1'b0);
        step();
        check_output("arb_rd_dv", data_valid, 1'b1);
        check_output("arb_rd_last", rw_last, 1'b1);
        check_output("arb_rd_data", data, pat_11);
        check_output("arb_awready_after", awready, 1'b1);
        step();
        awvalid = 1'b0;
        check_output("arb_w_wready", wready, 1'b1);
        write_beat(pat_77, '1, 1'b1);
        write_resp();
        read_addr(32'h80, 8'd0);
        step(); step();
        check_output("arb_readback", data, pat_77);
        check_output("arb_readback_last", rw_last, 1'b1);
        step();

        // Early wlast: burst still runs three beats, error is sticky.
        check_output("pe_before", proto_err, 1'b0);
        write_addr(32'h100, 8'd2);
        write_beat(pat_11, '1, 1'b0);
        write_beat(pat_22, '1, 1'b1);
        check_output("pe_set", proto_err, 1'b1);
        check_output("pe_wready_b2", wready, 1'b1);
        write_beat(pat_33, '1, 1'b1);
        check_output("pe_bvalid", bvalid, 1'b1);
        write_resp();
        check_output("pe_sticky", proto_err, 1'b1);

        // Reset in the middle of a read burst.
        read_addr(32'h40, 8'd3);
        step(); step();
        check_output("mr_dv_before", data_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_output("mr_dv_async", data_valid, 1'b0);
        check_output("mr_pe_cleared", proto_err, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_output("mr_arready", arready, 1'b1);
        check_output("mr_dv_after", data_valid, 1'b0);
        read_addr(32'h40, 8'd0);
        step(); step();
        check_output("mr_retained", data, pat_11);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
